// File: rtl/mod4_mult_pkg.sv
// Width, shift and saturation-limit helpers shared by the module-4 fixed-point multiplier.
package mod4_mult_pkg;

  // Widest intermediate any supported configuration may need.
  localparam int unsigned LimW = 128;

  function automatic int unsigned prod_width(input int unsigned i1, input int unsigned f1,
                                             input int unsigned i2, input int unsigned f2,
                                             input bit sign1, input bit sign2);
    return i1 + f1 + i2 + f2 + ((sign1 != sign2) ? 32'd1 : 32'd0);
  endfunction

  // Positive result: right shift of the product; negative: left shift.
  function automatic int shift_amt(input int unsigned f1, input int unsigned f2,
                                   input int unsigned f3);
    return int'(f1 + f2) - int'(f3);
  endfunction

  function automatic int unsigned rshift_amt(input int s);
    return (s > 0) ? int'(s) : 0;
  endfunction

  function automatic int unsigned lshift_amt(input int s);
    return (s < 0) ? int'(-s) : 0;
  endfunction

  // Leaves headroom for the rounding carry and for the saturation limits themselves.
  function automatic int unsigned work_width(input int unsigned pw, input int unsigned ls,
                                             input int unsigned ow);
    return (((pw + ls) > ow) ? (pw + ls) : ow) + 2;
  endfunction

  function automatic logic signed [LimW-1:0] sat_hi(input int unsigned ow, input bit osign);
    logic signed [LimW-1:0] one;
    one = LimW'(1);
    if (osign) return (one <<< (ow - 1)) - one;
    return (one <<< ow) - one;
  endfunction

  function automatic logic signed [LimW-1:0] sat_lo(input int unsigned ow, input bit osign);
    logic signed [LimW-1:0] one;
    one = LimW'(1);
    if (osign) return -(one <<< (ow - 1));
    return '0;
  endfunction

endpackage

// File: rtl/mod4_mult_sat.sv
// Combinational realignment of the full product: optional round, shift, saturate.
// Build option MOD4_MULT_ROUND_EN selects round-half-up instead of truncation.
module mod4_mult_sat
  import mod4_mult_pkg::*;
#(
  parameter int unsigned PW    = 32,
  parameter int          S     = 14,
  parameter int unsigned OW    = 16,
  parameter bit          PSign = 1'b1,
  parameter bit          OSign = 1'b1
) (
  input  logic [PW-1:0] prod_i,
  output logic [OW-1:0] tdata_o,
  output logic          overflow_o
);

  localparam int unsigned RS = rshift_amt(S);
  localparam int unsigned LS = lshift_amt(S);
  localparam int unsigned WW = work_width(PW, LS, OW);

  localparam logic signed [LimW-1:0] HiFull = sat_hi(OW, OSign);
  localparam logic signed [LimW-1:0] LoFull = sat_lo(OW, OSign);
  localparam logic signed [WW-1:0]   Hi     = HiFull[WW-1:0];
  localparam logic signed [WW-1:0]   Lo     = LoFull[WW-1:0];

`ifdef MOD4_MULT_ROUND_EN
  localparam logic signed [WW-1:0] RndInc = (RS > 0) ? (WW'(1) << ((RS > 0) ? RS - 1 : 0)) : '0;
`else
  localparam logic signed [WW-1:0] RndInc = '0;
`endif

  logic signed [WW-1:0] p_ext;
  logic signed [WW-1:0] p_rnd;
  logic signed [WW-1:0] p_aln;

  always_comb begin
    if (PSign) p_ext = {{(WW - PW){prod_i[PW-1]}}, prod_i};
    else       p_ext = {{(WW - PW){1'b0}}, prod_i};
    p_rnd = p_ext + RndInc;
    // Only one of RS / LS is ever non-zero.
    p_aln = (p_rnd >>> RS) <<< LS;

    tdata_o    = p_aln[OW-1:0];
    overflow_o = 1'b0;
    if (p_aln > Hi) begin
      tdata_o    = Hi[OW-1:0];
      overflow_o = 1'b1;
    end else if (p_aln < Lo) begin
      tdata_o    = Lo[OW-1:0];
      overflow_o = 1'b1;
    end
  end

endmodule

// File: rtl/mod4_fxp_mult.sv
// Two-stage fixed-point multiplier joining streams A and B into a saturated Q(i3.f3) stream.
// Rounding is enabled by defining MOD4_MULT_ROUND_EN (see mod4_mult_sat).
module mod4_fxp_mult
  import mod4_mult_pkg::*;
#(
  parameter int unsigned i1    = 2,
  parameter int unsigned f1    = 14,
  parameter int unsigned i2    = 2,
  parameter int unsigned f2    = 14,
  parameter int unsigned i3    = 2,
  parameter int unsigned f3    = 14,
  parameter bit          sign1 = 1'b1,
  parameter bit          sign2 = 1'b1,
  parameter bit          osign = sign1 || sign2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [i1+f1-1:0] input_tdata_a,
  input  logic             input_tvalid_a,
  output logic             input_tready_a,
  input  logic [i2+f2-1:0] input_tdata_b,
  input  logic             input_tvalid_b,
  output logic             input_tready_b,
  output logic [i3+f3-1:0] output_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             overflow
);

  localparam int unsigned AW = i1 + f1;
  localparam int unsigned BW = i2 + f2;
  localparam int unsigned OW = i3 + f3;
  localparam int unsigned PW = prod_width(i1, f1, i2, f2, sign1, sign2);
  localparam int          S  = shift_amt(f1, f2, f3);

  logic          en;
  logic          rdy;
  logic          acc;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;
  logic [OW-1:0] sat_data;
  logic          sat_ovf;

  logic          s1_valid_d, s1_valid_q;
  logic [PW-1:0] s1_prod_d,  s1_prod_q;
  logic          out_valid_d, out_valid_q;
  logic [OW-1:0] out_data_d,  out_data_q;
  logic          ovf_d,       ovf_q;

  always_comb begin
    if (sign1) a_ext = {{(PW - AW){input_tdata_a[AW-1]}}, input_tdata_a};
    else       a_ext = {{(PW - AW){1'b0}}, input_tdata_a};
    if (sign2) b_ext = {{(PW - BW){input_tdata_b[BW-1]}}, input_tdata_b};
    else       b_ext = {{(PW - BW){1'b0}}, input_tdata_b};
    // The exact product always fits PW bits, so the modular PW-bit product is lossless.
    prod = a_ext * b_ext;
  end

  mod4_mult_sat #(
    .PW    (PW),
    .S     (S),
    .OW    (OW),
    .PSign (sign1 || sign2),
    .OSign (osign)
  ) u_sat (
    .prod_i     (s1_prod_q),
    .tdata_o    (sat_data),
    .overflow_o (sat_ovf)
  );

  always_comb begin
    en  = !out_valid_q || output_tready;
    rdy = en && !reset_n;
    acc = input_tvalid_a && input_tvalid_b && rdy;

    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_d       = ovf_q;
    if (en) begin
      s1_valid_d  = acc;
      out_valid_d = s1_valid_q;
      if (acc) s1_prod_d = prod;
      if (s1_valid_q) begin
        out_data_d = sat_data;
        ovf_d      = sat_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  assign input_tready_a = rdy;
  assign input_tready_b = rdy;
  assign output_tdata   = out_data_q;
  assign output_tvalid  = out_valid_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_mod4_fxp_mult.sv
// Directed-vector bench for mod4_fxp_mult at default parameters (Q2.14 signed).
module tb_mod4_fxp_mult;

  logic        clk;
  logic        reset_n;
  logic [15:0] input_tdata_a;
  logic        input_tvalid_a;
  logic        input_tready_a;
  logic [15:0] input_tdata_b;
  logic        input_tvalid_b;
  logic        input_tready_b;
  logic [15:0] output_tdata;
  logic        output_tvalid;
  logic        output_tready;
  logic        overflow;

  int n_cmp;
  int n_err;

  mod4_fxp_mult u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .input_tdata_a  (input_tdata_a),
    .input_tvalid_a (input_tvalid_a),
    .input_tready_a (input_tready_a),
    .input_tdata_b  (input_tdata_b),
    .input_tvalid_b (input_tvalid_b),
    .input_tready_b (input_tready_b),
    .output_tdata   (output_tdata),
    .output_tvalid  (output_tvalid),
    .output_tready  (output_tready),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated transfer into an idle pipeline with output_tready held high.
  task automatic xfer(input logic [15:0] a, input logic [15:0] b, output logic v_early,
                      output logic v_late, output logic [15:0] d, output logic o);
    @(posedge clk);
    #1;
    input_tdata_a  = a;
    input_tdata_b  = b;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b1;
    @(posedge clk);
    #1;
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    v_early = output_tvalid;
    @(posedge clk);
    #1;
    v_late = output_tvalid;
    d      = output_tdata;
    o      = overflow;
  endtask

  logic [15:0] va [9];
  logic [15:0] vb [9];
  logic [15:0] vd [9];
  logic        vo [9];
  logic [15:0] bpa [4];
  logic [15:0] bpb [4];
  logic [15:0] bpd [4];

  logic        v_early, v_late, o, rdy;
  logic [15:0] d, last_d;
  int          idx, k, nbeats;
  logic [15:0] ra, rb;
  longint      diff;

  initial begin
    n_cmp = 0;
    n_err = 0;
    va[0] = 16'h2000; vb[0] = 16'h2000; vd[0] = 16'h1000; vo[0] = 1'b0;
    va[1] = 16'h6000; vb[1] = 16'hC000; vd[1] = 16'hA000; vo[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h8000; vd[2] = 16'h7FFF; vo[2] = 1'b1;
    va[3] = 16'h7FFF; vb[3] = 16'h8000; vd[3] = 16'h8000; vo[3] = 1'b1;
`ifdef MOD4_MULT_ROUND_EN
    va[4] = 16'h0001; vb[4] = 16'h2000; vd[4] = 16'h0001; vo[4] = 1'b0;
    va[5] = 16'hFFFF; vb[5] = 16'h0001; vd[5] = 16'h0000; vo[5] = 1'b0;
`else
    va[4] = 16'h0001; vb[4] = 16'h2000; vd[4] = 16'h0000; vo[4] = 1'b0;
    va[5] = 16'hFFFF; vb[5] = 16'h0001; vd[5] = 16'hFFFF; vo[5] = 1'b0;
`endif
    va[6] = 16'h4000; vb[6] = 16'h4000; vd[6] = 16'h4000; vo[6] = 1'b0;
    va[7] = 16'h7FFF; vb[7] = 16'h7FFF; vd[7] = 16'h7FFF; vo[7] = 1'b1;
    va[8] = 16'h7FFF; vb[8] = 16'h4000; vd[8] = 16'h7FFF; vo[8] = 1'b0;

    bpa[0] = 16'h4000; bpb[0] = 16'h2000; bpd[0] = 16'h2000;
    bpa[1] = 16'h2000; bpb[1] = 16'hC000; bpd[1] = 16'hE000;
    bpa[2] = 16'h1000; bpb[2] = 16'h4000; bpd[2] = 16'h1000;
    bpa[3] = 16'h3000; bpb[3] = 16'h4000; bpd[3] = 16'h3000;

    reset_n        = 1'b1;
    input_tdata_a  = '0;
    input_tdata_b  = '0;
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    output_tready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 32'(output_tvalid), 32'd0);
    check_eq("rst_tdata", 32'(output_tdata), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_tready_a", 32'(input_tready_a), 32'd0);
    check_eq("rst_tready_b", 32'(input_tready_b), 32'd0);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("post_rst_tready", 32'(input_tready_a), 32'd1);

    // Directed vectors, with latency check
    for (int i = 0; i < 9; i++) begin
      xfer(va[i], vb[i], v_early, v_late, d, o);
      check_eq($sformatf("vec%0d_early", i), 32'(v_early), 32'd0);
      check_eq($sformatf("vec%0d_valid", i), 32'(v_late), 32'd1);
      check_eq($sformatf("vec%0d_data", i), 32'(d), 32'(vd[i]));
      check_eq($sformatf("vec%0d_ovf", i), 32'(o), 32'(vo[i]));
    end
    @(posedge clk);
    #1;

    // Backpressure: fill both stages with output_tready low
    output_tready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      input_tdata_a  = bpa[idx < 4 ? idx : 3];
      input_tdata_b  = bpb[idx < 4 ? idx : 3];
      input_tvalid_a = (idx < 4);
      input_tvalid_b = (idx < 4);
      @(negedge clk);
      rdy = input_tready_a;
      @(posedge clk);
      #1;
      if (rdy && idx < 4) idx++;
    end
    check_eq("bp_accepted", 32'(idx), 32'd2);
    check_eq("bp_ready_low", 32'(input_tready_a), 32'd0);
    check_eq("bp_hold_valid", 32'(output_tvalid), 32'd1);
    check_eq("bp_hold_data", 32'(output_tdata), 32'(bpd[0]));
    @(posedge clk);
    #1;
    check_eq("bp_hold_data2", 32'(output_tdata), 32'(bpd[0]));

    output_tready = 1'b1;
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      input_tdata_a  = bpa[idx < 4 ? idx : 3];
      input_tdata_b  = bpb[idx < 4 ? idx : 3];
      input_tvalid_a = (idx < 4);
      input_tvalid_b = (idx < 4);
      @(negedge clk);
      rdy = input_tready_a;
      if (output_tvalid) begin
        check_eq($sformatf("bp_out%0d", k), 32'(output_tdata), 32'(bpd[k]));
        k++;
      end
      @(posedge clk);
      #1;
      if (rdy && idx < 4) idx++;
    end
    check_eq("bp_count", 32'(k), 32'd4);
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    nbeats = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (output_tvalid) nbeats++;
    end
    check_eq("bp_no_dup", 32'(nbeats), 32'd0);

    // Only A valid for three cycles, then B joins
    @(posedge clk);
    #1;
    input_tdata_a  = 16'h2000;
    input_tdata_b  = 16'h4000;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b0;
    nbeats = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (output_tvalid) nbeats++;
      @(posedge clk);
      #1;
    end
    check_eq("aonly_no_beat", 32'(nbeats), 32'd0);
    input_tvalid_b = 1'b1;
    @(posedge clk);
    #1;
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    last_d = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (output_tvalid) begin
        nbeats++;
        last_d = output_tdata;
      end
    end
    check_eq("join_beats", 32'(nbeats), 32'd1);
    check_eq("join_data", 32'(last_d), 32'h2000);

    // Reset with both stages occupied
    @(posedge clk);
    #1;
    input_tdata_a  = 16'h2000;
    input_tdata_b  = 16'h2000;
    input_tvalid_a = 1'b1;
    input_tvalid_b = 1'b1;
    @(posedge clk);
    #1;
    input_tdata_a = 16'h4000;
    input_tdata_b = 16'h4000;
    @(posedge clk);
    #1;
    input_tvalid_a = 1'b0;
    input_tvalid_b = 1'b0;
    check_eq("midrst_pre_valid", 32'(output_tvalid), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_valid", 32'(output_tvalid), 32'd0);
    check_eq("midrst_ready", 32'(input_tready_b), 32'd0);
    reset_n = 1'b0;
    nbeats  = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (output_tvalid) nbeats++;
    end
    check_eq("midrst_no_stale", 32'(nbeats), 32'd0);

    // Random operands of magnitude below 1.0, so no saturation
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(0, 32767) - 16384);
      rb = 16'($urandom_range(0, 32767) - 16384);
      xfer(ra, rb, v_early, v_late, d, o);
      diff = longint'($signed(ra)) * longint'($signed(rb)) - longint'($signed(d)) * 64'sd16384;
      check_eq($sformatf("rnd%0d_err(a=%h b=%h d=%h)", i, ra, rb, d),
               32'((diff <= 64'sd16384) && (diff >= -64'sd16384)), 32'd1);
      check_eq($sformatf("rnd%0d_ovf", i), 32'(o), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
